program_memory_ctrl: RTL and testbench

PROGRAM_MEMORY_CTRL -- requirements
Module: program_memory_ctrl

---
 rtl/program_memory_ctrl.sv | 107 ++++++++++
 tb/tb_program_memory_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_ctrl.sv
// Program memory controller: clears a 256x8 RAM, loads a byte stream into it,
// then serves registered instruction fetches to the processor while it runs.
module program_memory_ctrl #(
  parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
  input  logic       clk_50m,
  input  logic       reset,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic       reload,
  input  logic [7:0] pc,
  output logic [7:0] test_instruction,
  output logic       instr_valid,
  output logic       cpu_run,
  output logic [8:0] load_count
);

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  state_t     state;
  logic [7:0] mem [0:255];
  logic [7:0] clr_addr;
  logic [7:0] wr_ptr;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;

  // Single write port shared by the clear sweep and the loader; RUN never writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_addr;
    mem_wdata = CLEAR_VALUE;
    if (!reset) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
      end else if (state == LOAD && load_valid && load_ready) begin
        mem_we    = 1'b1;
        mem_waddr = wr_ptr;
        mem_wdata = load_data;
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state            <= CLEAR;
      clr_addr         <= 8'd0;
      wr_ptr           <= 8'd0;
      load_count       <= 9'd0;
      load_ready       <= 1'b0;
      cpu_run          <= 1'b0;
      instr_valid      <= 1'b0;
      test_instruction <= 8'h00;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 8'd1;
          if (clr_addr == 8'hFF) begin
            state      <= LOAD;
            load_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (load_valid && load_ready) begin
            wr_ptr     <= wr_ptr + 8'd1;
            load_count <= load_count + 9'd1;
            // Filling the last address ends the load even without load_last.
            if (load_last || wr_ptr == 8'hFF) begin
              state      <= RUN;
              load_ready <= 1'b0;
              cpu_run    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (reload) begin
            state            <= CLEAR;
            clr_addr         <= 8'd0;
            wr_ptr           <= 8'd0;
            load_count       <= 9'd0;
            cpu_run          <= 1'b0;
            instr_valid      <= 1'b0;
            test_instruction <= 8'h00;
          end else begin
            test_instruction <= mem[pc];
            instr_valid      <= 1'b1;
          end
        end
        default: begin
          state            <= CLEAR;
          clr_addr         <= 8'd0;
          load_ready       <= 1'b0;
          cpu_run          <= 1'b0;
          instr_valid      <= 1'b0;
          test_instruction <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_memory_ctrl.sv
// Directed bench for program_memory_ctrl: clear timing, loading, fetch latency,
// reload and mid-operation reset, each in its own scenario task.
module tb_program_memory_ctrl;

  logic       clk_50m = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       reload = 1'b0;
  logic [7:0] pc = 8'h00;
  logic [7:0] test_instruction;
  logic       instr_valid;
  logic       cpu_run;
  logic [8:0] load_count;

  int total = 0;
  int bad = 0;

  program_memory_ctrl dut (
    .clk_50m(clk_50m), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .reload(reload), .pc(pc),
    .test_instruction(test_instruction), .instr_valid(instr_valid), .cpu_run(cpu_run),
    .load_count(load_count)
  );

  always #5 clk_50m = ~clk_50m;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge clk_50m);
    @(negedge clk_50m);
  endtask

  task automatic apply_byte(input logic [7:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    cycle();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Waits for load_ready after entering CLEAR and requires exactly 256 clear edges.
  task automatic wait_clear(input string name);
    int n = 0;
    while (!load_ready && n < 400) begin
      cycle();
      n++;
    end
    total++;
    if (n !== 256) begin
      bad++;
      $display("[TB] FAIL %s clear edges: got %0d expected 256", name, n);
    end
  endtask

  task automatic fetch(input string name, input logic [7:0] addr, input logic [7:0] exp);
    pc = addr;
    cycle();
    total++;
    if (test_instruction !== exp || instr_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s pc=%h: got instr=%h valid=%b expected instr=%h valid=1",
               name, addr, test_instruction, instr_valid, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    total++;
    if ({load_ready, cpu_run, instr_valid, test_instruction, load_count} !== 20'h0) begin
      bad++;
      $display("[TB] FAIL reset_state: got ready=%b run=%b valid=%b instr=%h count=%0d expected all 0",
               load_ready, cpu_run, instr_valid, test_instruction, load_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_clear_timing();
    int early = 0;
    for (int i = 1; i <= 255; i++) begin
      reload = (i == 100);
      cycle();
      if (load_ready !== 1'b0) early++;
    end
    reload = 1'b0;
    total++;
    if (early !== 0) begin
      bad++;
      $display("[TB] FAIL clear_ready_low: got %0d early ready cycles expected 0", early);
    end
    cycle();
    total++;
    if (load_ready !== 1'b1 || load_count !== 9'd0 || cpu_run !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clear_done: got ready=%b count=%0d run=%b expected ready=1 count=0 run=0",
               load_ready, load_count, cpu_run);
    end
  endtask

  task automatic test_basic_load();
    apply_byte(8'h11, 1'b0);
    reload = 1'b1;
    load_last = 1'b1;
    cycle();
    reload = 1'b0;
    load_last = 1'b0;
    total++;
    if (load_ready !== 1'b1 || load_count !== 9'd1 || cpu_run !== 1'b0) begin
      bad++;
      $display("[TB] FAIL load_ignore: got ready=%b count=%0d run=%b expected ready=1 count=1 run=0",
               load_ready, load_count, cpu_run);
    end
    apply_byte(8'h22, 1'b0);
    apply_byte(8'h33, 1'b1);
    total++;
    if (cpu_run !== 1'b1 || load_ready !== 1'b0 || load_count !== 9'd3 ||
        instr_valid !== 1'b0 || test_instruction !== 8'h00) begin
      bad++;
      $display("[TB] FAIL run_entry: got run=%b ready=%b count=%0d valid=%b instr=%h expected 1 0 3 0 00",
               cpu_run, load_ready, load_count, instr_valid, test_instruction);
    end
    fetch("basic", 8'h01, 8'h22);
    fetch("basic", 8'h05, 8'h00);
    fetch("basic", 8'h00, 8'h11);
    fetch("basic", 8'h02, 8'h33);
  endtask

  task automatic test_reload();
    reload = 1'b1;
    cycle();
    reload = 1'b0;
    total++;
    if (cpu_run !== 1'b0 || instr_valid !== 1'b0 || test_instruction !== 8'h00 ||
        load_count !== 9'd0 || load_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reload_exit: got run=%b valid=%b instr=%h count=%0d ready=%b expected 0 0 00 0 0",
               cpu_run, instr_valid, test_instruction, load_count, load_ready);
    end
    wait_clear("reload");
    apply_byte(8'hA5, 1'b1);
    cycle();
    fetch("reload", 8'h01, 8'h00);
    fetch("reload", 8'h00, 8'hA5);
  endtask

  task automatic test_full_load();
    reload = 1'b1;
    cycle();
    reload = 1'b0;
    wait_clear("full");
    for (int i = 0; i < 255; i++) apply_byte(8'(i), 1'b0);
    total++;
    if (load_ready !== 1'b1 || cpu_run !== 1'b0 || load_count !== 9'd255) begin
      bad++;
      $display("[TB] FAIL full_255: got ready=%b run=%b count=%0d expected 1 0 255",
               load_ready, cpu_run, load_count);
    end
    apply_byte(8'hFF, 1'b0);
    total++;
    if (cpu_run !== 1'b1 || load_ready !== 1'b0 || load_count !== 9'd256) begin
      bad++;
      $display("[TB] FAIL full_256: got run=%b ready=%b count=%0d expected 1 0 256",
               cpu_run, load_ready, load_count);
    end
    fetch("full", 8'hFF, 8'hFF);
    fetch("full", 8'h80, 8'h80);
    fetch("full", 8'h00, 8'h00);
  endtask

  task automatic test_toggle_valid();
    logic [7:0] vals [5] = '{8'h3C, 8'h5A, 8'h7E, 8'h81, 8'hC3};
    reload = 1'b1;
    cycle();
    reload = 1'b0;
    wait_clear("toggle");
    for (int k = 0; k < 5; k++) begin
      if (k == 4) apply_byte(vals[k], 1'b1);
      else begin
        apply_byte(vals[k], 1'b0);
        load_data = 8'hEE;
        load_last = 1'b1;
        cycle();
        load_last = 1'b0;
      end
    end
    total++;
    if (load_count !== 9'd5 || cpu_run !== 1'b1) begin
      bad++;
      $display("[TB] FAIL toggle_count: got count=%0d run=%b expected 5 1", load_count, cpu_run);
    end
    for (int k = 0; k < 5; k++) fetch("toggle", 8'(k), vals[k]);
    fetch("toggle", 8'h05, 8'h00);
  endtask

  task automatic test_reset_mid();
    reload = 1'b1;
    cycle();
    reload = 1'b0;
    wait_clear("mid");
    apply_byte(8'h44, 1'b0);
    apply_byte(8'h55, 1'b0);
    reset = 1'b1;
    load_valid = 1'b1;
    cycle();
    reset = 1'b0;
    load_valid = 1'b0;
    total++;
    if (load_ready !== 1'b0 || load_count !== 9'd0 || cpu_run !== 1'b0 || test_instruction !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_in_load: got ready=%b count=%0d run=%b instr=%h expected 0 0 0 00",
               load_ready, load_count, cpu_run, test_instruction);
    end
    wait_clear("reset_load");
    apply_byte(8'h77, 1'b1);
    cycle();
    fetch("mid", 8'h00, 8'h77);
    reset = 1'b1;
    reload = 1'b1;
    cycle();
    reset = 1'b0;
    reload = 1'b0;
    total++;
    if (cpu_run !== 1'b0 || instr_valid !== 1'b0 || test_instruction !== 8'h00 || load_count !== 9'd0) begin
      bad++;
      $display("[TB] FAIL reset_in_run: got run=%b valid=%b instr=%h count=%0d expected 0 0 00 0",
               cpu_run, instr_valid, test_instruction, load_count);
    end
    wait_clear("reset_run");
    total++;
    if (test_instruction !== 8'h00 || instr_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL instr_hold_load: got instr=%h valid=%b expected 00 0",
               test_instruction, instr_valid);
    end
  endtask

  initial begin
    @(negedge clk_50m);
    test_reset();
    test_clear_timing();
    test_basic_load();
    test_reload();
    test_full_load();
    test_toggle_valid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
